pc_sequencer: RTL and testbench

- Fetch-stage controller that owns the program counter and sequences instruction fetch for the pipelined MIPS core.
- Selects the next PC from sequential, branch/jump, exception-vector and ERET sources, and runs a req/ready handshake with instruction memory.
- Buffers one fetched word across decode stalls and detects illegal fetch addresses.
- Feeds the IF/ID boundary: if_valid, if_inst, if_pc, if_adel.

---
 rtl/pc_sequencer_if.sv | 10 +
 rtl/pc_sequencer.sv | 153 +++++++++++++++
 tb/tb_pc_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch port: request/address out, ready/data back.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: owns the PC, sequences imem fetches, buffers one
// word across decode stalls and flags illegal fetch addresses.
//
// state | meaning
// BOOT  | one idle cycle after clr, no fetch issued
// FETCH | request imem at pc_now (or trap an illegal pc_now)
// HOLD  | one fetched word parked in buf while decode is stalled
// FAULT | illegal fetch delivered with if_adel, waiting for a redirect
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IMEM_LAST  = 32'h0000_6FFC
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  stall,
  input  logic                  br_taken,
  input  logic [31:0]           br_target,
  input  logic                  exc_req,
  input  logic [31:0]           exc_pc,
  input  logic                  eret,
  pc_sequencer_if.master        imem,
  output logic [31:0]           pc_now,
  output logic                  if_valid,
  output logic [31:0]           if_inst,
  output logic [31:0]           if_pc,
  output logic                  if_adel,
  output logic [31:0]           epc
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] bufpc_q, bufpc_d;
  logic        valid_q, valid_d;
  logic        adel_q, adel_d;
  logic        pc_legal;
  logic [31:0] pc_inc;

  assign pc_legal = (pc_q[1:0] == 2'b00) && (pc_q >= IMEM_BASE) && (pc_q <= IMEM_LAST);
  assign pc_inc   = pc_q + 32'd4;

  // State and pipeline registers; clr wins over everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      inst_q  <= '0;
      ifpc_q  <= '0;
      buf_q   <= '0;
      bufpc_q <= '0;
      valid_q <= 1'b0;
      adel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      inst_q  <= inst_d;
      ifpc_q  <= ifpc_d;
      buf_q   <= buf_d;
      bufpc_q <= bufpc_d;
      valid_q <= valid_d;
      adel_q  <= adel_d;
    end
  end

  // Next-state: redirects first (exc > eret > branch), then per-state fetch flow.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    inst_d  = inst_q;
    ifpc_d  = ifpc_q;
    buf_d   = buf_q;
    bufpc_d = bufpc_q;
    valid_d = valid_q;
    adel_d  = adel_q;

    if (state_q == BOOT) begin
      state_d = FETCH;
    end else if (exc_req) begin
      epc_d   = exc_pc;
      pc_d    = EXC_VECTOR;
      valid_d = 1'b0;
      state_d = FETCH;
    end else if (eret) begin
      pc_d    = epc_q;
      valid_d = 1'b0;
      state_d = FETCH;
    end else if (br_taken && !stall) begin
      pc_d    = br_target;
      valid_d = 1'b0;
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (!pc_legal) begin
            inst_d  = '0;
            ifpc_d  = pc_q;
            adel_d  = 1'b1;
            valid_d = 1'b1;
            state_d = FAULT;
          end else if (imem.imem_ready) begin
            pc_d = pc_inc;
            if (stall) begin
              buf_d   = imem.imem_rdata;
              bufpc_d = pc_q;
              state_d = HOLD;
            end else begin
              inst_d  = imem.imem_rdata;
              ifpc_d  = pc_q;
              adel_d  = 1'b0;
              valid_d = 1'b1;
            end
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            inst_d  = buf_q;
            ifpc_d  = bufpc_q;
            adel_d  = 1'b0;
            valid_d = 1'b1;
            state_d = FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  // Request depends only on registered state, never on imem_rdata.
  always_comb begin
    imem.imem_req  = (state_q == FETCH) && pc_legal;
    imem.imem_addr = pc_q;
  end

  assign pc_now   = pc_q;
  assign if_valid = valid_q;
  assign if_inst  = inst_q;
  assign if_pc    = ifpc_q;
  assign if_adel  = adel_q;
  assign epc      = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed walk through the fetch scenarios, then random traffic, all checked
// cycle by cycle against a behavioural fetch model.
module tb_pc_sequencer;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] VEC    = 32'h0000_4180;
  localparam logic [31:0] LO     = 32'h0000_3000;
  localparam logic [31:0] HI     = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        clr, stall, br_taken, exc_req, eret;
  logic [31:0] br_target, exc_pc;
  logic [31:0] pc_now, if_inst, if_pc, epc;
  logic        if_valid, if_adel;

  pc_sequencer_if imem ();

  pc_sequencer dut (
    .clk(clk), .clr(clr), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .exc_req(exc_req), .exc_pc(exc_pc), .eret(eret), .imem(imem.master),
    .pc_now(pc_now), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .if_adel(if_adel), .epc(epc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: where the fetcher is and what decode currently sees.
  logic [31:0] m_pc, m_epc, m_inst, m_ifpc, m_buf, m_bufpc;
  logic        m_valid, m_adel, m_booting, m_parked, m_trapped;

  function automatic logic fetchable(input logic [31:0] a);
    return (a % 4 == 0) && (a >= LO) && (a <= HI);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic c, input logic s, input logic b, input logic [31:0] bt,
                            input logic x, input logic [31:0] xpc, input logic e,
                            input logic rdy, input logic [31:0] rd);
    logic redirect;
    redirect = 1'b0;
    if (c) begin
      m_pc = RST_PC; m_epc = 0; m_inst = 0; m_ifpc = 0; m_valid = 0; m_adel = 0;
      m_booting = 1; m_parked = 0; m_trapped = 0;
    end else if (m_booting) begin
      m_booting = 0;
    end else begin
      if (x) begin
        m_epc = xpc; m_pc = VEC; redirect = 1;
      end else if (e) begin
        m_pc = m_epc; redirect = 1;
      end else if (b && !s) begin
        m_pc = bt; redirect = 1;
      end
      if (redirect) begin
        m_valid = 0; m_parked = 0; m_trapped = 0;
      end else if (m_trapped) begin
        // waiting for a redirect
      end else if (m_parked) begin
        if (!s) begin
          m_inst = m_buf; m_ifpc = m_bufpc; m_adel = 0; m_valid = 1; m_parked = 0;
        end
      end else if (!fetchable(m_pc)) begin
        m_inst = 0; m_ifpc = m_pc; m_adel = 1; m_valid = 1; m_trapped = 1;
      end else if (rdy) begin
        if (s) begin
          m_buf = rd; m_bufpc = m_pc; m_parked = 1;
        end else begin
          m_inst = rd; m_ifpc = m_pc; m_adel = 0; m_valid = 1;
        end
        m_pc = m_pc + 32'd4;
      end else if (!s) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic step(input logic c, input logic s, input logic b, input logic [31:0] bt,
                      input logic x, input logic [31:0] xpc, input logic e, input logic rdy);
    logic [31:0] rd;
    rd = $urandom;
    clr = c; stall = s; br_taken = b; br_target = bt; exc_req = x; exc_pc = xpc; eret = e;
    imem.imem_ready = rdy; imem.imem_rdata = rd;
    model_step(c, s, b, bt, x, xpc, e, rdy, rd);
    @(posedge clk);
    #1;
    chk("pc_now",    pc_now, m_pc);
    chk("imem_addr", imem.imem_addr, m_pc);
    chk("imem_req",  {31'd0, imem.imem_req},
        {31'd0, !m_booting && !m_trapped && !m_parked && fetchable(m_pc)});
    chk("if_valid",  {31'd0, if_valid}, {31'd0, m_valid});
    chk("if_inst",   if_inst, m_inst);
    chk("if_pc",     if_pc, m_ifpc);
    chk("if_adel",   {31'd0, if_adel}, {31'd0, m_adel});
    chk("epc",       epc, m_epc);
  endtask

  task automatic idle(input logic s, input logic rdy);
    step(0, s, 0, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    logic [31:0] tgt;
    clr = 1; stall = 0; br_taken = 0; br_target = 0; exc_req = 0; exc_pc = 0; eret = 0;
    imem.imem_ready = 1; imem.imem_rdata = 0;
    m_buf = 0; m_bufpc = 0;

    // Reset and sequential fetch
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_pc", pc_now, 32'h3000);
    chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
    idle(0, 1);
    chk("first_addr", imem.imem_addr, 32'h3000);
    idle(0, 1);
    chk("seq_ifpc0", if_pc, 32'h3000);
    chk("seq_addr1", imem.imem_addr, 32'h3004);

    // Wait states then stall buffering at 0x3004
    idle(0, 0);
    idle(0, 0);
    chk("wait_addr", imem.imem_addr, 32'h3004);
    idle(1, 1);
    idle(1, 1);
    idle(1, 1);
    chk("hold_ifpc", if_pc, 32'h3000);
    idle(0, 1);
    chk("unhold_ifpc", if_pc, 32'h3004);
    chk("after_hold_addr", imem.imem_addr, 32'h3008);

    // Branch abandons pending fetch; same request under stall is ignored
    step(0, 0, 1, 32'h3100, 0, 0, 0, 1);
    chk("br_addr", imem.imem_addr, 32'h3100);
    chk("br_flush", {31'd0, if_valid}, 32'd0);
    step(0, 1, 1, 32'h3200, 0, 0, 0, 0);
    chk("br_stalled", imem.imem_addr, 32'h3100);

    // Exception beats branch, then ERET
    step(0, 0, 1, 32'h3300, 1, 32'h3010, 0, 1);
    chk("exc_epc", epc, 32'h3010);
    chk("exc_pc", pc_now, 32'h4180);
    idle(0, 1);
    idle(0, 1);
    step(0, 1, 0, 0, 0, 0, 1, 1);
    chk("eret_pc", pc_now, 32'h3010);

    // Illegal fetch: misaligned, then out of range
    step(0, 0, 1, 32'h3002, 0, 0, 0, 1);
    idle(0, 1);
    chk("mis_adel", {31'd0, if_adel}, 32'd1);
    chk("mis_ifpc", if_pc, 32'h3002);
    idle(0, 1);
    chk("fault_hold_pc", pc_now, 32'h3002);
    step(0, 0, 0, 0, 1, 32'h3002, 0, 1);
    chk("fault_exit", imem.imem_addr, 32'h4180);
    step(0, 0, 1, 32'h7000, 0, 0, 0, 1);
    idle(0, 1);
    chk("oor_ifpc", if_pc, 32'h7000);
    step(0, 0, 0, 0, 1, 32'h7000, 0, 1);

    // Reset while a word is parked in HOLD
    idle(0, 1);
    idle(1, 1);
    step(1, 1, 0, 0, 0, 0, 0, 1);
    chk("clr_hold_pc", pc_now, 32'h3000);
    idle(0, 1);
    idle(0, 1);
    chk("clr_no_stale", if_pc, 32'h3000);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) tgt = $urandom;
      else tgt = LO + 32'd4 * $urandom_range(0, 32'hFFF);
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) == 0, tgt,
           $urandom_range(0, 39) == 0, LO + 32'd4 * $urandom_range(0, 32'hFFF),
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) < 7);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
